// File: rtl/cm0_pkg.sv
// Types and constants shared by the core pipeline: the flag register layout,
// the register index type, the PC index and the ALU opcode set.
package cm0_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 4;
   localparam int PC_IDX    = 15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_ADC = 4'h1,
      ALU_SUB = 4'h2,
      ALU_SBC = 4'h3,
      ALU_AND = 4'h4,
      ALU_ORR = 4'h5,
      ALU_EOR = 4'h6,
      ALU_BIC = 4'h7,
      ALU_LSL = 4'h8,
      ALU_LSR = 4'h9,
      ALU_ASR = 4'hA,
      ALU_ROR = 4'hB,
      ALU_NOT = 4'hC
   } alu_op_t;

endpackage

// File: rtl/alu_writeback.sv
// Execute/writeback stage: one-deep valid/ready register after the ALU, the
// architectural NZCV register, register-file/PC write strobes and forwarding.
module alu_writeback #(
   parameter int DATA_W = 32,
   parameter int RIDX_W = 4,
   parameter int PC_IDX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [RIDX_W-1:0] ex_rd,
   input  logic              ex_wr_en,
   input  logic              ex_flag_en,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flag_q,
   output logic [3:0]        apsr_flag,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RIDX_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic              wb_pc_we,
   input  logic [RIDX_W-1:0] fwd_idx_a,
   input  logic [RIDX_W-1:0] fwd_idx_b,
   output logic              fwd_hit_a,
   output logic              fwd_hit_b,
   output logic [DATA_W-1:0] fwd_data,
   output logic [31:0]       retired
);
   import cm0_pkg::*;

   localparam logic [RIDX_W-1:0] PC_SEL = RIDX_W'(PC_IDX);

   logic              valid_reg,   valid_next;
   logic [RIDX_W-1:0] rd_reg,      rd_next;
   logic [DATA_W-1:0] data_reg,    data_next;
   logic              wr_en_reg,   wr_en_next;
   flags_t            apsr_reg,    apsr_next;
   logic [31:0]       retired_reg, retired_next;

   logic accept;
   logic consume;
   logic is_pc;

   assign ex_ready = ~flush & (~valid_reg | wb_ready);
   assign accept   = ex_valid & ex_ready;
   assign consume  = valid_reg & wb_ready;

   always_comb begin
      valid_next   = valid_reg;
      rd_next      = rd_reg;
      data_next    = data_reg;
      wr_en_next   = wr_en_reg;
      apsr_next    = apsr_reg;
      retired_next = retired_reg;

      // An accept overwrites a consumed entry in the same edge, so no bubble.
      if (accept) begin
         valid_next = 1'b1;
         rd_next    = ex_rd;
         data_next  = alu_result;
         wr_en_next = ex_wr_en;
      end else if (consume || flush) begin
         valid_next = 1'b0;
      end

      // Flags commit at accept so the very next ALU op sees them.
      if (accept && ex_flag_en)
         apsr_next = flags_t'(alu_flag_q);

      if (consume)
         retired_next = retired_reg + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg   <= 1'b0;
         rd_reg      <= '0;
         data_reg    <= '0;
         wr_en_reg   <= 1'b0;
         apsr_reg    <= '0;
         retired_reg <= '0;
      end else begin
         valid_reg   <= valid_next;
         rd_reg      <= rd_next;
         data_reg    <= data_next;
         wr_en_reg   <= wr_en_next;
         apsr_reg    <= apsr_next;
         retired_reg <= retired_next;
      end
   end

   assign is_pc     = (rd_reg == PC_SEL);
   assign wb_valid  = valid_reg;
   assign wb_rd     = rd_reg;
   assign wb_data   = data_reg;
   assign wb_we     = valid_reg & wr_en_reg & ~is_pc;
   assign wb_pc_we  = valid_reg & wr_en_reg & is_pc;
   assign apsr_flag = apsr_reg;
   assign retired   = retired_reg;
   assign fwd_data  = data_reg;

   logic [RIDX_W-1:0] fwd_idx [2];
   logic [1:0]        fwd_hit;

   assign fwd_idx[0] = fwd_idx_a;
   assign fwd_idx[1] = fwd_idx_b;

   // A PC-destination entry never forwards; the PC is read from its own path.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hit[gi] = valid_reg & wr_en_reg & (rd_reg == fwd_idx[gi])
                         & (fwd_idx[gi] != PC_SEL);
   end

   assign fwd_hit_a = fwd_hit[0];
   assign fwd_hit_b = fwd_hit[1];

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: handshake, flag commit, PC strobe,
// forwarding, flush, reset and retire-counter wrap.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_rd;
   logic        ex_wr_en;
   logic        ex_flag_en;
   logic [31:0] alu_result;
   logic [3:0]  alu_flag_q;
   logic [3:0]  apsr_flag;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_we;
   logic        wb_pc_we;
   logic [3:0]  fwd_idx_a;
   logic [3:0]  fwd_idx_b;
   logic        fwd_hit_a;
   logic        fwd_hit_b;
   logic [31:0] fwd_data;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_rd      (ex_rd),
      .ex_wr_en   (ex_wr_en),
      .ex_flag_en (ex_flag_en),
      .alu_result (alu_result),
      .alu_flag_q (alu_flag_q),
      .apsr_flag  (apsr_flag),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_we      (wb_we),
      .wb_pc_we   (wb_pc_we),
      .fwd_idx_a  (fwd_idx_a),
      .fwd_idx_b  (fwd_idx_b),
      .fwd_hit_a  (fwd_hit_a),
      .fwd_hit_b  (fwd_hit_b),
      .fwd_data   (fwd_data),
      .retired    (retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
      $display("check %-22s got=%h exp=%h", tag, got, exp);
   endtask

   // Advance one clock edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic [3:0] rd, input logic we,
                           input logic fe, input logic [31:0] res, input logic [3:0] fl);
      ex_valid   = v;
      ex_rd      = rd;
      ex_wr_en   = we;
      ex_flag_en = fe;
      alu_result = res;
      alu_flag_q = fl;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
      fwd_idx_a = 4'd0; fwd_idx_b = 4'd0;
      drive_ex(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 4'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_wb_valid",   32'(wb_valid),  32'd0);
      check("rst_wb_rd",      32'(wb_rd),     32'd0);
      check("rst_wb_data",    wb_data,        32'd0);
      check("rst_wb_we",      32'(wb_we),     32'd0);
      check("rst_wb_pc_we",   32'(wb_pc_we),  32'd0);
      check("rst_apsr",       32'(apsr_flag), 32'd0);
      check("rst_retired",    retired,        32'd0);
      check("rst_ex_ready",   32'(ex_ready),  32'd1);

      // ADDS r2: 0xFFFFFFFF + 1 -> 0, flags Z,C
      wb_ready = 1'b1;
      drive_ex(1'b1, 4'd2, 1'b1, 1'b1, 32'h0, 4'b0110);
      tick();
      ex_valid = 1'b0;
      fwd_idx_a = 4'd2; fwd_idx_b = 4'd3;
      #1;
      check("adds_wb_valid",  32'(wb_valid),  32'd1);
      check("adds_wb_we",     32'(wb_we),     32'd1);
      check("adds_wb_rd",     32'(wb_rd),     32'd2);
      check("adds_wb_data",   wb_data,        32'd0);
      check("adds_apsr",      32'(apsr_flag), 32'b0110);
      check("adds_fwd_hit_a", 32'(fwd_hit_a), 32'd1);
      check("adds_fwd_hit_b", 32'(fwd_hit_b), 32'd0);
      tick();
      check("adds_retired",   retired,        32'd1);
      check("adds_drained",   32'(wb_valid),  32'd0);

      // CMP: flags only, no register write, no forwarding
      drive_ex(1'b1, 4'd5, 1'b0, 1'b1, 32'h0000_1234, 4'b1000);
      tick();
      ex_valid = 1'b0;
      fwd_idx_a = 4'd5; fwd_idx_b = 4'd0;
      #1;
      check("cmp_wb_valid",   32'(wb_valid),  32'd1);
      check("cmp_wb_we",      32'(wb_we),     32'd0);
      check("cmp_wb_pc_we",   32'(wb_pc_we),  32'd0);
      check("cmp_apsr",       32'(apsr_flag), 32'b1000);
      check("cmp_fwd_hit_a",  32'(fwd_hit_a), 32'd0);
      check("cmp_fwd_hit_b",  32'(fwd_hit_b), 32'd0);
      tick();
      check("cmp_retired",    retired,        32'd2);

      // Stall: first entry held for 3 cycles while a second waits
      wb_ready = 1'b0;
      drive_ex(1'b1, 4'd3, 1'b1, 1'b0, 32'hAAAA_5555, 4'b1111);
      tick();
      drive_ex(1'b1, 4'd4, 1'b1, 1'b1, 32'h0BAD_F00D, 4'b0011);
      #1;
      check("stall_ex_ready", 32'(ex_ready),  32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_wb_data",  wb_data,        32'hAAAA_5555);
         check("stall_wb_rd",    32'(wb_rd),     32'd3);
         check("stall_ex_ready", 32'(ex_ready),  32'd0);
      end
      check("stall_apsr",     32'(apsr_flag), 32'b1000);
      wb_ready = 1'b1;
      #1;
      check("resume_ex_ready", 32'(ex_ready), 32'd1);
      tick();
      ex_valid = 1'b0;
      #1;
      check("b2b_wb_valid",   32'(wb_valid),  32'd1);
      check("b2b_wb_data",    wb_data,        32'h0BAD_F00D);
      check("b2b_fwd_data",   fwd_data,       32'h0BAD_F00D);
      check("b2b_wb_rd",      32'(wb_rd),     32'd4);
      check("b2b_retired",    retired,        32'd3);
      check("b2b_apsr",       32'(apsr_flag), 32'b0011);
      tick();
      check("b2b_retired2",   retired,        32'd4);
      check("b2b_drained",    32'(wb_valid),  32'd0);

      // Write to PC, held (wb_ready=0) for the flush step
      wb_ready = 1'b0;
      drive_ex(1'b1, 4'd15, 1'b1, 1'b0, 32'h0000_0100, 4'b0000);
      tick();
      ex_valid = 1'b0;
      fwd_idx_a = 4'd15; fwd_idx_b = 4'd15;
      #1;
      check("pc_wb_pc_we",    32'(wb_pc_we),  32'd1);
      check("pc_wb_we",       32'(wb_we),     32'd0);
      check("pc_wb_data",     wb_data,        32'h0000_0100);
      check("pc_fwd_hit_a",   32'(fwd_hit_a), 32'd0);
      check("pc_fwd_hit_b",   32'(fwd_hit_b), 32'd0);

      // Flush while held with a pending instruction
      drive_ex(1'b1, 4'd6, 1'b1, 1'b1, 32'h0000_0066, 4'b1111);
      flush = 1'b1;
      #1;
      check("flush_ex_ready", 32'(ex_ready),  32'd0);
      tick();
      flush = 1'b0;
      ex_valid = 1'b0;
      #1;
      check("flush_wb_valid", 32'(wb_valid),  32'd0);
      check("flush_apsr",     32'(apsr_flag), 32'b0011);
      check("flush_retired",  retired,        32'd4);

      // Build apsr=1111, retired=5, then stall and reset
      wb_ready = 1'b1;
      drive_ex(1'b1, 4'd7, 1'b1, 1'b1, 32'h0000_0077, 4'b1111);
      tick();
      drive_ex(1'b1, 4'd8, 1'b1, 1'b0, 32'h0000_0088, 4'b0000);
      tick();
      ex_valid = 1'b0;
      wb_ready = 1'b0;
      tick();
      check("prerst_retired", retired,        32'd5);
      check("prerst_apsr",    32'(apsr_flag), 32'b1111);
      check("prerst_valid",   32'(wb_valid),  32'd1);
      rst = 1'b1;
      wb_ready = 1'b1;
      drive_ex(1'b1, 4'd9, 1'b1, 1'b1, 32'h0000_0099, 4'b0101);
      tick();
      rst = 1'b0;
      ex_valid = 1'b0;
      #1;
      check("mrst_wb_valid",  32'(wb_valid),  32'd0);
      check("mrst_wb_rd",     32'(wb_rd),     32'd0);
      check("mrst_wb_data",   wb_data,        32'd0);
      check("mrst_wb_we",     32'(wb_we),     32'd0);
      check("mrst_wb_pc_we",  32'(wb_pc_we),  32'd0);
      check("mrst_apsr",      32'(apsr_flag), 32'd0);
      check("mrst_retired",   retired,        32'd0);

      // Retire counter wrap
      force dut.retired_reg = 32'hFFFF_FFFF;
      #1;
      release dut.retired_reg;
      #1;
      check("wrap_preset",    retired,        32'hFFFF_FFFF);
      drive_ex(1'b1, 4'd1, 1'b1, 1'b0, 32'h0000_0011, 4'b0000);
      tick();
      ex_valid = 1'b0;
      tick();
      check("wrap_retired",   retired,        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute/writeback stage directly downstream of the ALU.
- Captures the ALU result and NZCV flags into a one-deep valid/ready pipeline register and holds the architectural APSR flag register, which feeds back to the ALU flag input.
- Drives the register-file write port, provides a forwarding port for the operand stage, and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width.
- RIDX_W, 4, register index width (r0..r15).
- PC_IDX, 15, register index that denotes the PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX stage presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_rd  in  RIDX_W  destination register
- ex_wr_en  in  1  instruction writes rd
- ex_flag_en  in  1  instruction updates NZCV (S-suffix, CMP)
- alu_result  in  DATA_W  ALU result
- alu_flag_q  in  4  ALU flags {N,Z,C,V}
- apsr_flag  out  4  committed NZCV, wired to the ALU flag input
- flush  in  1  discard the held entry; block accept this cycle
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  register file / PC logic consumes the entry
- wb_rd  out  RIDX_W  write index
- wb_data  out  DATA_W  write data
- wb_we  out  1  register write strobe: wb_valid & held wr_en & (wb_rd != PC_IDX)
- wb_pc_we  out  1  PC write strobe: wb_valid & held wr_en & (wb_rd == PC_IDX)
- fwd_idx_a  in  RIDX_W  operand A source index
- fwd_idx_b  in  RIDX_W  operand B source index
- fwd_hit_a  out  1  held entry matches A
- fwd_hit_b  out  1  held entry matches B
- fwd_data  out  DATA_W  equals wb_data
- retired  out  32  retired-instruction count

Behaviour:
- Reset: wb_valid=0; wb_rd=0; wb_data=0; wb_we=0; wb_pc_we=0; apsr_flag=4'b0000; retired=0. Reset overrides flush and all handshakes.
- ex_ready = ~flush & (~wb_valid | wb_ready). Combinational, no dependence on ex_valid.
- Accept = ex_valid & ex_ready. On the following edge the entry loads {rd, result, wr_en} and wb_valid=1. Latency: EX to writeback is 1 cycle.
- Consume = wb_valid & wb_ready. Without a simultaneous accept, wb_valid clears on the next edge. With accept in the same cycle, the new entry replaces the old one, giving full throughput with no bubble.
- Held entry stays stable while wb_valid & ~wb_ready.
- Flags commit at accept time, not at writeback: on accept with ex_flag_en=1, apsr_flag <= alu_flag_q at that edge. The next ALU operation sees the new flags, so an ADDS/ADCS chain needs no stall. Without accept or ex_flag_en, apsr_flag holds.
- flush: on the next edge wb_valid=0 and nothing is accepted. Flags committed by already-accepted instructions stay committed. A flush in the same cycle as consume still counts that retire.
- retired increments by 1 per consume and wraps 0xFFFFFFFF→0.
- Forwarding:
  - fwd_hit_a = wb_valid & held wr_en & (wb_rd == fwd_idx_a) & (fwd_idx_a != PC_IDX); fwd_hit_b likewise.
  - Forwarding is combinational.
  - A PC-destination entry never forwards.
- An entry with wr_en=0 (CMP/TST) still occupies the stage, asserts wb_valid, and counts as retired, but wb_we=wb_pc_we=0.
- ex_flag_en=1 with wr_en=0 is legal (compare); flags update and the register file is untouched.

Decomposition:
- Shared package cm0_pkg:
  - typedef flags_t (packed N,Z,C,V) and named bit positions FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - typedef reg_idx_t;
  - constant PC_IDX=15;
  - ALU opcode enum (ADD=0 … NOT=C), shared with ALU and decoder.
- The stage is a single module. No sub-module: the pipeline register and APSR are too small to split.

Test Plan:
- ADDS r2 with result 0xFFFFFFFF+0x1 (alu_result=0, flag_q=0110), wb_ready=1 → next cycle: wb_we=1, wb_rd=2, wb_data=0, apsr_flag=0110, retired=1.
- CMP with flag_q=1000 and ex_wr_en=0 → wb_valid=1, wb_we=0, apsr_flag=1000, retired increments; fwd_hit_a=0 for any index.
- wb_ready=0 for 3 cycles with a second ex_valid pending → ex_ready=0 and entry stable throughout; raise wb_ready → back-to-back accept and consume with no bubble, wb_data switches to the second result.
- Write to rd=15 with data 0x00000100 → wb_pc_we=1, wb_we=0, fwd_hit_a=0 with fwd_idx_a=15.
- flush asserted while an entry is held and ex_valid=1 → ex_ready=0; next cycle wb_valid=0, apsr_flag unchanged, retired unchanged.
- rst asserted mid-stall with apsr_flag=1111 and retired=5 → next edge: all outputs at reset values; retired preset to 0xFFFFFFFF (via force) then consume → wraps to 0.
